// File: rtl/fpu_sequencer.sv
// Instruction sequencer for the 64-bit FP unit: fetches from a 256 x 16 instruction
// memory, decodes, issues operations, waits for completion with a timeout, commits results.
module fpu_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  input  logic [15:0] inst_i,
  input  logic        fpu_done_i,
  output logic [7:0]  pc_o,
  output logic        stop_o,
  output logic [1:0]  fpu_op_o,
  output logic        fpu_start_o,
  output logic [3:0]  ra_addr_o,
  output logic [3:0]  rb_addr_o,
  output logic [3:0]  wr_addr_o,
  output logic        wr_en_o,
  output logic        halted_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [15:0] retired_o
);

  localparam int unsigned PC_W   = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned RET_W  = 16;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_ADD  = 4'h1;
  localparam logic [3:0] OPC_DIV  = 4'h4;
  localparam logic [3:0] OPC_HALT = 4'hF;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_OVERFLOW = 2'b11;

  localparam logic [PC_W-1:0] PC_LAST = {PC_W{1'b1}};
  // EXEC cycle count starts at 0, so this limit puts HALT exactly TIMEOUT cycles after ISSUE
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 2);

  typedef struct packed {
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
  } inst_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_EXEC,
    S_WRITE,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RET_W-1:0]  retired_q, retired_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [ADDR_W-1:0] rb_q, rb_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              stop_q, stop_d;
  logic              start_q, start_d;
  logic              wr_en_q, wr_en_d;
  logic              halted_q, halted_d;

  inst_t ir;
  logic  retire;
  logic  advance;

  assign ir = inst_t'(inst_i);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    retired_d  = retired_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    wa_d       = wa_q;
    op_d       = op_q;
    retire     = 1'b0;
    advance    = 1'b0;

    case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (run_i) begin
          state_d    = S_FETCH;
          retired_d  = '0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end
      end

      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        ra_d = ir.rs1;
        rb_d = ir.rs2;
        wa_d = ir.rd;
        op_d = OP_W'(ir.opcode - 4'd1);
        if ((ir.opcode >= OPC_ADD) && (ir.opcode <= OPC_DIV)) begin
          state_d = S_ISSUE;
        end else if (ir.opcode == OPC_NOP) begin
          retire  = 1'b1;
          advance = 1'b1;
        end else if (ir.opcode == OPC_HALT) begin
          retire  = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d    = S_HALT;
          err_d      = 1'b1;
          err_code_d = ERR_ILLEGAL;
        end
      end

      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_EXEC;
      end

      // Completion wins over timeout on the final allowed cycle
      S_EXEC: begin
        if (fpu_done_i) begin
          state_d = S_WRITE;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d    = S_HALT;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WRITE: begin
        retire  = 1'b1;
        advance = 1'b1;
      end

      S_HALT: begin
        if (run_i) begin
          state_d    = S_FETCH;
          pc_d       = '0;
          retired_d  = '0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The last address never wraps; stepping past it is an overflow error
    if (advance) begin
      if (pc_q == PC_LAST) begin
        state_d    = S_HALT;
        err_d      = 1'b1;
        err_code_d = ERR_OVERFLOW;
      end else begin
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
    end

    if (retire && (retired_q != {RET_W{1'b1}})) begin
      retired_d = retired_q + RET_W'(1);
    end

    stop_d   = (state_d == S_IDLE) || (state_d == S_HALT);
    halted_d = (state_d == S_HALT);
    start_d  = (state_d == S_ISSUE);
    wr_en_d  = (state_d == S_WRITE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      retired_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      ra_q       <= '0;
      rb_q       <= '0;
      wa_q       <= '0;
      op_q       <= '0;
      stop_q     <= 1'b1;
      start_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      retired_q  <= retired_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      wa_q       <= wa_d;
      op_q       <= op_d;
      stop_q     <= stop_d;
      start_q    <= start_d;
      wr_en_q    <= wr_en_d;
      halted_q   <= halted_d;
    end
  end

  assign pc_o        = pc_q;
  assign stop_o      = stop_q;
  assign fpu_op_o    = op_q;
  assign fpu_start_o = start_q;
  assign ra_addr_o   = ra_q;
  assign rb_addr_o   = rb_q;
  assign wr_addr_o   = wa_q;
  assign wr_en_o     = wr_en_q;
  assign halted_o    = halted_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign retired_o   = retired_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Bench for fpu_sequencer: an instruction-level model expands each program run into a
// per-cycle expected output trace; a compare process checks the DUT against it every cycle.
module tb_fpu_sequencer;

  localparam int DEPTH = 16384;

  typedef struct packed {
    logic [7:0]  pc;
    logic        stop;
    logic        start;
    logic        wr;
    logic        halted;
    logic        err;
    logic [1:0]  code;
    logic [15:0] ret;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  wa;
    logic [1:0]  op;
    logic        chk_op;
  } rec_t;

  localparam rec_t RESET_REC = '{pc: 8'h00, stop: 1'b1, start: 1'b0, wr: 1'b0, halted: 1'b0,
                                 err: 1'b0, code: 2'b00, ret: 16'h0000, ra: 4'h0, rb: 4'h0,
                                 wa: 4'h0, op: 2'b00, chk_op: 1'b0};

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        run;
  logic [15:0] inst = 16'h0000;
  logic        fpu_done;
  logic [7:0]  pc_o;
  logic        stop_o;
  logic [1:0]  fpu_op_o;
  logic        fpu_start_o;
  logic [3:0]  ra_addr_o;
  logic [3:0]  rb_addr_o;
  logic [3:0]  wr_addr_o;
  logic        wr_en_o;
  logic        halted_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [15:0] retired_o;

  fpu_sequencer #(.TIMEOUT(64)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .run_i       (run),
    .inst_i      (inst),
    .fpu_done_i  (fpu_done),
    .pc_o        (pc_o),
    .stop_o      (stop_o),
    .fpu_op_o    (fpu_op_o),
    .fpu_start_o (fpu_start_o),
    .ra_addr_o   (ra_addr_o),
    .rb_addr_o   (rb_addr_o),
    .wr_addr_o   (wr_addr_o),
    .wr_en_o     (wr_en_o),
    .halted_o    (halted_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .retired_o   (retired_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory: synchronous read, held while stopped
  logic [15:0] mem [0:255];
  always @(posedge clk) if (!stop_o) inst <= mem[pc_o];

  int   lat [0:255];
  rec_t exp_a [0:DEPTH-1];
  bit   exp_v [0:DEPTH-1];
  int   n_run  = 0;
  int   n_fail = 0;
  int   n_start = 0;
  int   n_wr    = 0;
  logic [1:0] op_log [0:15];
  logic [3:0] wa_log [0:15];

  logic [3:0] m_ra = 4'h0, m_rb = 4'h0, m_wa = 4'h0;
  logic [1:0] m_op = 2'b00;
  int         m_idx = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // FP unit stand-in: done pulses D cycles after each start, stray pulses otherwise
  initial begin
    int cnt;
    int rsp_idx;
    bit pend;
    cnt = 0; rsp_idx = 0; pend = 0; fpu_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_ni) begin
        pend = 0;
        fpu_done = 1'b0;
      end else if (fpu_start_o) begin
        cnt = lat[rsp_idx % 256];
        rsp_idx++;
        pend = 1;
        fpu_done = ($urandom_range(0, 3) == 0);
      end else if (pend) begin
        cnt--;
        fpu_done = (cnt == 0);
        if (cnt == 0) pend = 0;
      end else begin
        fpu_done = ($urandom_range(0, 7) == 0);
      end
    end
  end

  // Per-cycle comparison against the expected trace
  initial begin
    rec_t last;
    rec_t act;
    last = RESET_REC;
    forever begin
      @(negedge clk);
      if (cyc < DEPTH && exp_v[cyc]) last = exp_a[cyc];
      act.pc = pc_o;        act.stop = stop_o;     act.start = fpu_start_o;
      act.wr = wr_en_o;     act.halted = halted_o; act.err = err_o;
      act.code = err_code_o; act.ret = retired_o;  act.ra = ra_addr_o;
      act.rb = rb_addr_o;   act.wa = wr_addr_o;
      act.op = last.chk_op ? fpu_op_o : last.op;
      act.chk_op = last.chk_op;
      n_run++;
      if (act !== last) begin
        n_fail++;
        $display("FAIL cycle %0d outputs: got pc=%h stop=%b st=%b we=%b hl=%b err=%b code=%h ret=%0d ra=%h rb=%h wa=%h op=%h, expected pc=%h stop=%b st=%b we=%b hl=%b err=%b code=%h ret=%0d ra=%h rb=%h wa=%h op=%h",
                 cyc, act.pc, act.stop, act.start, act.wr, act.halted, act.err, act.code, act.ret,
                 act.ra, act.rb, act.wa, act.op, last.pc, last.stop, last.start, last.wr,
                 last.halted, last.err, last.code, last.ret, last.ra, last.rb, last.wa, last.op);
      end
      n_run++;
      if (fpu_start_o && wr_en_o) begin
        n_fail++;
        $display("FAIL cycle %0d start_wr_exclusive: got both high, expected at most one", cyc);
      end
      if (fpu_start_o) begin op_log[n_start % 16] = fpu_op_o; n_start++; end
      if (wr_en_o)     begin wa_log[n_wr % 16] = wr_addr_o;   n_wr++;    end
    end
  end

  task automatic put(input int k, input logic [7:0] p, input logic st, input logic we,
                     input logic hl, input logic [1:0] code, input logic [15:0] r);
    rec_t e;
    e.pc = p; e.stop = hl; e.start = st; e.wr = we; e.halted = hl;
    e.err = (code != 2'b00); e.code = code; e.ret = r;
    e.ra = m_ra; e.rb = m_rb; e.wa = m_wa; e.op = m_op; e.chk_op = st;
    if (k < DEPTH) begin exp_a[k] = e; exp_v[k] = 1'b1; end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] r);
    return (r == 16'hFFFF) ? r : r + 16'd1;
  endfunction

  // Instruction-level model: run begins at cycle c, first FETCH at c+1; returns HALT cycle
  task automatic model_run(input int c, output int h);
    int k;
    int d;
    int opc;
    bit fin;
    logic [7:0]  p;
    logic [15:0] r;
    logic [15:0] w;
    logic [1:0]  code;
    k = c + 1; p = 8'h00; r = 16'h0000; code = 2'b00; fin = 0;
    while (!fin) begin
      put(k, p, 0, 0, 0, 2'b00, r); k++;
      put(k, p, 0, 0, 0, 2'b00, r); k++;
      w = mem[p];
      opc = int'(w[15:12]);
      m_wa = w[11:8]; m_ra = w[7:4]; m_rb = w[3:0];
      if (opc == 0) begin
        r = sat_inc(r);
        if (p == 8'hFF) begin code = 2'b11; fin = 1; end
        else p = p + 8'd1;
      end else if (opc == 15) begin
        r = sat_inc(r);
        fin = 1;
      end else if (opc >= 1 && opc <= 4) begin
        m_op = 2'(opc - 1);
        put(k, p, 1, 0, 0, 2'b00, r); k++;
        d = lat[m_idx % 256];
        m_idx++;
        if (d <= 63) begin
          for (int i = 0; i < d; i++) begin put(k, p, 0, 0, 0, 2'b00, r); k++; end
          put(k, p, 0, 1, 0, 2'b00, r); k++;
          r = sat_inc(r);
          if (p == 8'hFF) begin code = 2'b11; fin = 1; end
          else p = p + 8'd1;
        end else begin
          for (int i = 0; i < 63; i++) begin put(k, p, 0, 0, 0, 2'b00, r); k++; end
          code = 2'b10;
          fin = 1;
        end
      end else begin
        code = 2'b01;
        fin = 1;
      end
    end
    put(k, p, 0, 0, 1, code, r);
    h = k;
  endtask

  task automatic do_run(output int h);
    @(posedge clk); #1;
    run = 1'b1;
    model_run(cyc, h);
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  task automatic wait_until(input int h, input bit rnd_run);
    while (cyc < h + 8) begin
      @(posedge clk); #1;
      run = rnd_run && (cyc < h - 1) && ($urandom_range(0, 9) == 0);
    end
    run = 1'b0;
  endtask

  initial begin
    int h;
    int s0;
    int w0;
    int t_s;
    int t_h;
    int len;
    int kind;
    rst_ni = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      kind = $urandom_range(0, 19);
      if (kind < 16)      lat[i] = $urandom_range(1, 6);
      else if (kind < 19) lat[i] = $urandom_range(60, 63);
      else                lat[i] = $urandom_range(64, 70);
    end
    for (int i = 0; i < DEPTH; i++) exp_v[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Idle after reset with run low
    repeat (10) @(posedge clk);
    #1;
    chk("idle_pc", pc_o, 0);
    chk("idle_stop", stop_o, 1);
    chk("idle_no_start", fpu_start_o, 0);

    // ADD then SUB then HALT, done three cycles after each start
    mem[0] = 16'h1321; mem[1] = 16'h2654; mem[2] = 16'hF000;
    lat[m_idx % 256] = 3; lat[(m_idx + 1) % 256] = 3;
    s0 = n_start; w0 = n_wr;
    do_run(h);
    wait_until(h, 0);
    chk("alu_starts", n_start - s0, 2);
    chk("alu_op0", op_log[s0 % 16], 0);
    chk("alu_op1", op_log[(s0 + 1) % 16], 1);
    chk("alu_writes", n_wr - w0, 2);
    chk("alu_waddr0", wa_log[w0 % 16], 3);
    chk("alu_waddr1", wa_log[(w0 + 1) % 16], 6);
    chk("alu_halted", halted_o, 1);
    chk("alu_err", err_o, 0);
    chk("alu_retired", retired_o, 3);
    chk("alu_pc", pc_o, 2);

    // NOP, NOP, HALT
    mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'hF000;
    s0 = n_start;
    do_run(h);
    wait_until(h, 0);
    chk("nop_starts", n_start - s0, 0);
    chk("nop_retired", retired_o, 3);
    chk("nop_pc", pc_o, 2);

    // Illegal opcode at pc 0
    mem[0] = 16'h7123;
    s0 = n_start;
    do_run(h);
    wait_until(h, 0);
    chk("illegal_code", err_code_o, 1);
    chk("illegal_err", err_o, 1);
    chk("illegal_retired", retired_o, 0);
    chk("illegal_starts", n_start - s0, 0);

    // Whole memory of NOPs runs off the end
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    do_run(h);
    wait_until(h, 0);
    chk("ovf_code", err_code_o, 3);
    chk("ovf_retired", retired_o, 256);
    chk("ovf_pc", pc_o, 8'hFF);

    // ADD with done withheld until well after the timeout
    mem[0] = 16'h1321; mem[1] = 16'hF000;
    lat[m_idx % 256] = 100;
    w0 = n_wr;
    do_run(h);
    t_s = -1000;
    for (int i = 0; i < 20 && t_s < 0; i++) begin
      @(posedge clk); #1;
      if (fpu_start_o) t_s = cyc;
    end
    t_h = -1;
    for (int i = 0; i < 100 && t_h < 0; i++) begin
      @(posedge clk); #1;
      if (halted_o) t_h = cyc;
    end
    chk("timeout_latency", t_h - t_s, 64);
    chk("timeout_code", err_code_o, 2);
    chk("timeout_no_write", n_wr - w0, 0);
    repeat (60) @(posedge clk);
    #1;
    chk("late_done_halted", halted_o, 1);
    chk("late_done_code", err_code_o, 2);
    chk("late_done_no_write", n_wr - w0, 0);
    mem[0] = 16'hF000;
    do_run(h);
    wait_until(h, 0);
    chk("restart_err", err_o, 0);
    chk("restart_retired", retired_o, 1);
    chk("restart_pc", pc_o, 0);

    // Asynchronous reset in the middle of EXEC
    mem[0] = 16'h4ABC; mem[1] = 16'hF000;
    lat[m_idx % 256] = 20;
    do_run(h);
    repeat (4) @(posedge clk);
    #2;
    rst_ni = 1'b0;
    for (int k = cyc; k < cyc + 700 && k < DEPTH; k++) exp_v[k] = 1'b0;
    m_ra = 4'h0; m_rb = 4'h0; m_wa = 4'h0; m_op = 2'b00;
    if (cyc < DEPTH) begin exp_a[cyc] = RESET_REC; exp_v[cyc] = 1'b1; end
    @(negedge clk); #1;
    chk("rst_pc", pc_o, 0);
    chk("rst_stop", stop_o, 1);
    chk("rst_start", fpu_start_o, 0);
    chk("rst_wr", wr_en_o, 0);
    chk("rst_halted", halted_o, 0);
    chk("rst_err", {err_o, err_code_o}, 0);
    chk("rst_retired", retired_o, 0);
    chk("rst_addrs", {ra_addr_o, rb_addr_o, wr_addr_o, fpu_op_o}, 0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (3) @(posedge clk);

    // Random programs with stray done pulses and ignored run pulses
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(4, 14);
      for (int i = 0; i < len; i++) begin
        kind = $urandom_range(0, 19);
        if (kind < 6)        mem[i] = {4'h0, 12'($urandom)};
        else if (kind < 19)  mem[i] = {4'($urandom_range(1, 4)), 12'($urandom)};
        else                 mem[i] = {4'($urandom_range(5, 14)), 12'($urandom)};
      end
      mem[len] = {4'hF, 12'($urandom)};
      do_run(h);
      wait_until(h, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_sequencer.md
# fpu_sequencer

Sequences the 64-bit floating-point arithmetic unit from the 256 x 16 instruction memory. It drives `pc` and `stop` into the instruction memory, latches and decodes each 16-bit instruction, and issues operand and destination addresses to the data memory. It pulses a start to the FP unit, waits for its done with a timeout, commits the result, then advances. Program control is a `run` pulse; `halted`/`err` report completion.

## Interface
- `TIMEOUT`, 64: maximum EXEC cycles waiting for `fpu_done` before error.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `run`  in  1  start pulse; sampled only in IDLE or HALT.
- `inst`  in  16  instruction memory read data, valid one cycle after `pc`.
- `fpu_done`  in  1  FP unit result-valid pulse.
- `pc`  out  8  instruction memory address.
- `stop`  out  1  instruction memory hold/stop.
- `fpu_op`  out  2  00 add, 01 sub, 10 mul, 11 div.
- `fpu_start`  out  1  one-cycle issue pulse.
- `ra_addr`, `rb_addr`  out  4 each  data memory operand addresses.
- `wr_addr`  out  4  data memory destination address.
- `wr_en`  out  1  one-cycle result write strobe.
- `halted`  out  1  high in HALT.
- `err`  out  1  sticky error flag, cleared by `run`.
- `err_code`  out  2  00 none, 01 illegal opcode, 10 FPU timeout, 11 PC overflow.
- `retired`  out  16  retired instruction count, saturates at 16'hFFFF.

## Operation
- Instruction: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2. Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DIV, F HALT; 5-E illegal.
- States: IDLE, FETCH, DECODE, ISSUE, EXEC, WRITE, HALT.
- IDLE: `pc`=0, `stop`=1. `run`=1 -> FETCH. `retired` and `err` are cleared.
- FETCH: `stop`=0 and `pc` are presented. The next state is DECODE.
- DECODE: `inst` is latched into the internal IR. `ra_addr`/`rb_addr`/`wr_addr`/`fpu_op` are loaded from IR and held until the next DECODE.
  - ALU opcode -> ISSUE.
  - NOP -> `retired`+1, `pc`+1, FETCH.
  - HALT -> `retired`+1, HALT with `err`=0.
  - Illegal -> HALT with `err`=1, `err_code`=01.
- ISSUE: `fpu_start`=1 for exactly this cycle. `fpu_done` is ignored in this cycle. The next state is EXEC and the timeout counter is cleared.
- EXEC: wait for `fpu_done`.
  - `fpu_done`=1 -> WRITE.
  - Counter reaches `TIMEOUT` without done -> HALT with `err`=1, `err_code`=10. No write occurs.
- WRITE: `wr_en`=1 for one cycle and `retired`+1.
  - `pc`==8'hFF -> HALT with `err`=1, `err_code`=11. `pc` does not wrap.
  - Otherwise `pc`+1 -> FETCH.
- A NOP at `pc`=8'hFF behaves the same as WRITE at `pc`=8'hFF (overflow to HALT).
- HALT: `stop`=1, `halted`=1, and `pc` holds its last value. `run`=1 -> `pc`=0, `err`/`err_code`/`retired` are cleared, then FETCH.
- `run` outside IDLE/HALT has no effect. `fpu_done` outside EXEC is ignored.

## Timing
- Reset values: state IDLE, `pc`=0, `stop`=1. `fpu_start`=`wr_en`=`halted`=`err`=0. `err_code`=00, `retired`=0, all addresses 0, `fpu_op`=00.
- Reset asserted mid-operation returns the block to IDLE immediately (asynchronously). It does not wait for any pending `fpu_done`.
- All outputs are registered. `fpu_start` and `wr_en` are never high in the same cycle.
- ALU instruction latency from FETCH to the next FETCH is 4 + N cycles, where N ≥ 1 is the number of EXEC cycles up to and including the `fpu_done` cycle. The minimum is 5 cycles.
- NOP: 2 cycles per instruction.
- `halted` rises the cycle after DECODE of HALT, or after the timeout or overflow event.
- `retired` increments on the edge leaving WRITE or leaving NOP/HALT DECODE.
- Timeout: with `fpu_done` never asserted, HALT is entered exactly `TIMEOUT` cycles after the ISSUE cycle.

## Test plan
- Reset release with `run`=0 for 10 cycles -> IDLE held: `pc`=0, `stop`=1, no strobes.
- Program {0x1321, 0x2654, 0xF000} with `fpu_done` 3 cycles after each start, then `run` pulse:
  - `fpu_op` 00 then 01.
  - Writes to addresses 3 then 6.
  - `halted`=1, `err`=0, `retired`=3, `pc`=2.
- Program {0x0000, 0x0000, 0xF000} -> `pc` steps 0, 1, 2 at 2-cycle intervals, no `fpu_start`, `retired`=3.
- Instruction 0x7123 at `pc`=0 -> HALT with `err_code`=01, no `fpu_start`, `retired`=0.
- ADD with `fpu_done` withheld and `TIMEOUT`=64:
  - HALT 64 cycles after the start pulse, `err_code`=10, `wr_en` never asserted.
  - A `fpu_done` arriving later is ignored.
  - A `run` pulse restarts from `pc`=0 with `err` cleared.
- Memory filled with NOPs -> HALT after `pc`=8'hFF with `err_code`=11, `retired`=256 (no wrap to 0). Separately, `rst` pulsed low during EXEC -> all outputs return to their reset values.
